// File: rtl/shader_swizzle_seq.sv
// Four-lane swizzle sequencer: walks the output lanes one per cycle,
// steering an external 4:1 channel mux and collecting its result.
module shader_swizzle_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_swizzle,
  input  logic [15:0] in_frag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_frag,
  output logic [1:0]  mix_from,
  output logic [3:0]  mix_c3,
  output logic [3:0]  mix_c2,
  output logic [3:0]  mix_c1,
  output logic [3:0]  mix_c0,
  input  logic [3:0]  mix_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] frag_q;
  logic [7:0]  swz_q;
  logic [1:0]  sel;

  assign mix_c3 = frag_q[15:12];
  assign mix_c2 = frag_q[11:8];
  assign mix_c1 = frag_q[7:4];
  assign mix_c0 = frag_q[3:0];

  always_comb begin
    sel = swz_q[1:0];
    unique case (idx)
      2'd0: sel = swz_q[1:0];
      2'd1: sel = swz_q[3:2];
      2'd2: sel = swz_q[5:4];
      2'd3: sel = swz_q[7:6];
      default: sel = swz_q[1:0];
    endcase
  end

  // Handshake outputs are forced low during reset, before state clears.
  always_comb begin
    in_ready  = !rst &&
                ((state == IDLE) ||
                 ((state == DONE) && out_ready));
    out_valid = !rst && (state == DONE);
    busy      = !rst && (state != IDLE);
    mix_from  = 2'd0;
    if (!rst && (state == RUN))
      mix_from = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      frag_q   <= 16'd0;
      swz_q    <= 8'd0;
      out_frag <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            frag_q <= in_frag;
            swz_q  <= in_swizzle;
            idx    <= 2'd0;
            state  <= RUN;
          end
        end
        RUN: begin
          unique case (idx)
            2'd0: out_frag[3:0]   <= mix_wdata;
            2'd1: out_frag[7:4]   <= mix_wdata;
            2'd2: out_frag[11:8]  <= mix_wdata;
            2'd3: out_frag[15:12] <= mix_wdata;
            default: out_frag[3:0] <= mix_wdata;
          endcase
          idx <= idx + 2'd1;
          if (idx == 2'd3)
            state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              frag_q <= in_frag;
              swz_q  <= in_swizzle;
              idx    <= 2'd0;
              state  <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shader_swizzle_seq.sv
// Directed bench for shader_swizzle_seq with an external mux model
// and an expected-fragment queue filled at each accepted handshake.
module tb_shader_swizzle_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_swizzle;
  logic [15:0] in_frag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_frag;
  logic [1:0]  mix_from;
  logic [3:0]  mix_c3;
  logic [3:0]  mix_c2;
  logic [3:0]  mix_c1;
  logic [3:0]  mix_c0;
  logic [3:0]  mix_wdata;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  int          accepts = 0;
  logic [15:0] sb[$];
  logic [1:0]  mf_log[$];

  shader_swizzle_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_swizzle (in_swizzle),
    .in_frag    (in_frag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_frag   (out_frag),
    .mix_from   (mix_from),
    .mix_c3     (mix_c3),
    .mix_c2     (mix_c2),
    .mix_c1     (mix_c1),
    .mix_c0     (mix_c0),
    .mix_wdata  (mix_wdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mix_wdata = mix_c0;
    case (mix_from)
      2'd0: mix_wdata = mix_c0;
      2'd1: mix_wdata = mix_c1;
      2'd2: mix_wdata = mix_c2;
      2'd3: mix_wdata = mix_c3;
      default: mix_wdata = mix_c0;
    endcase
  end

  function automatic logic [15:0] swz_model(
    input logic [7:0] s, input logic [15:0] f);
    logic [15:0] r;
    logic [1:0]  k;
    r = 16'd0;
    for (int i = 0; i < 4; i++) begin
      k = s[2*i +: 2];
      r[4*i +: 4] = f[4*k +: 4];
    end
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) begin
      sb.push_back(swz_model(in_swizzle, in_frag));
      accepts++;
    end
    if (busy && !out_valid)
      mf_log.push_back(mix_from);
    if (out_valid && out_ready) begin
      if (sb.size() == 0)
        check("spurious_out", 64'(out_valid), 64'd0);
      else
        check("out_frag", 64'(out_frag), 64'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 12) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic run_pair(input string tag,
                          input logic [7:0] s,
                          input logic [15:0] f);
    int          n;
    logic [7:0]  seq;
    in_swizzle = s;
    in_frag    = f;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    mf_log.delete();
    step();
    in_valid = 1'b0;
    wait_valid(tag, n);
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_mixn"}, 64'(mf_log.size()), 64'd4);
    seq = 8'd0;
    for (int i = 0; i < 4 && i < mf_log.size(); i++)
      seq[2*i +: 2] = mf_log[i];
    check({tag, "_mixseq"}, 64'(seq), 64'(s));
    step();
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int          n;
    int          acc0;
    logic [15:0] held;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_swizzle = 8'd0;
    in_frag    = 16'd0;
    out_ready  = 1'b1;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mix_from", 64'(mix_from), 64'd0);
    check("rst_out_frag", 64'(out_frag), 64'd0);

    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_hold",
            64'({in_ready, busy, out_valid, mix_from, out_frag,
                 mix_c3, mix_c2, mix_c1, mix_c0}),
            64'({1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0}));
    end

    run_pair("identity", 8'hE4, 16'hABCD);
    run_pair("reverse", 8'h1B, 16'h1234);
    run_pair("broadcast", 8'h00, 16'h1234);
    run_pair("mixed", 8'h93, 16'hF05A);

    in_swizzle = 8'h4E;
    in_frag    = 16'h9C3F;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    step();
    in_swizzle = 8'hE4;
    in_frag    = 16'h5678;
    wait_valid("bp", n);
    acc0 = accepts;
    held = 16'h3F9C;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_frag", 64'(out_frag), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_no_accept", 64'(accepts - acc0), 64'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_reaccept", 64'(accepts - acc0), 64'd1);
    wait_valid("bp2", n);
    check("bp2_latency", 64'(n), 64'd4);
    step();
    check("bp_drained", 64'(sb.size()), 64'd0);

    in_swizzle = 8'h1B;
    in_frag    = 16'hCAFE;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    acc0       = accepts;
    step();
    in_swizzle = 8'hE1;
    in_frag    = 16'h0F3C;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (accepts - acc0 >= 2)
        in_valid = 1'b0;
      check("b2b_busy", 64'(busy), 64'(i <= 9));
      check("b2b_valid", 64'(out_valid),
            64'((i == 4) || (i == 9)));
    end
    check("b2b_accepts", 64'(accepts - acc0), 64'd2);
    check("b2b_drained", 64'(sb.size()), 64'd0);

    in_swizzle = 8'h39;
    in_frag    = 16'h2468;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    sb.delete();
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_out_frag", 64'(out_frag), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd0);
    check("mr_mix_from", 64'(mix_from), 64'd0);
    rst = 1'b0;
    #1;
    check("mr_ready_after", 64'(in_ready), 64'd1);
    run_pair("after_rst", 8'hC6, 16'h7E15);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shader_swizzle_seq.md
SHADER_SWIZZLE_SEQ -- requirements
Module: shader_swizzle_seq

Interface
REQ-001 The block SHALL have no parameters; lane width is fixed at 4 bits and lane count at 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream fragment/swizzle pair valid.
REQ-005 in_ready  output  1  block accepts a pair this cycle.
REQ-006 in_swizzle  input  8  per-output-lane source select: [7:6] lane 3, [5:4] lane 2, [3:2] lane 1, [1:0] lane 0.
REQ-007 in_frag  input  16  source fragment: [15:12] c3, [11:8] c2, [7:4] c1, [3:0] c0.
REQ-008 out_valid  output  1  swizzled fragment available.
REQ-009 out_ready  input  1  downstream accepts out_frag.
REQ-010 out_frag  output  16  swizzled fragment, same lane packing as in_frag.
REQ-011 mix_from  output  2  select driven to the external 4:1 channel mux.
REQ-012 mix_c3, mix_c2, mix_c1, mix_c0  output  4 each  captured source channels driven to the mux data inputs.
REQ-013 mix_wdata  input  4  mux result, treated as combinational from mix_from and mix_c*.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL be an FSM with states IDLE, RUN, DONE and a 2-bit lane index idx.
REQ-016 in_ready SHALL be (state==IDLE) or (state==DONE and out_ready), and SHALL be 0 while rst is high.
REQ-017 Accept: on in_valid and in_ready, the block SHALL capture in_frag into frag_q and in_swizzle into swz_q, clear idx to 0, and enter RUN.
REQ-018 mix_c3..mix_c0 SHALL always equal frag_q[15:12], [11:8], [7:4], [3:0] respectively.
REQ-019 In RUN, mix_from SHALL equal swz_q[2*idx+1:2*idx]; in IDLE and DONE it SHALL be 0.
REQ-020 Each RUN cycle, out_frag lane idx SHALL load mix_wdata at the edge and idx SHALL increment; at the edge where idx==3, the state SHALL go to DONE and idx SHALL wrap to 0.
REQ-021 Lanes not yet written in RUN SHALL hold prior contents; out_frag is only meaningful while out_valid is high.
REQ-022 out_valid SHALL be 1 exactly in DONE, and out_frag SHALL remain stable while out_valid is high.
REQ-023 In DONE with out_ready=1 and in_valid=0, the block SHALL go to IDLE; with in_valid=1, it SHALL accept the new pair and go directly to RUN.
REQ-024 In DONE with out_ready=0, the block SHALL hold all state regardless of in_valid.
REQ-025 Latency SHALL be 4 cycles from the accept edge to out_valid high; sustained throughput SHALL be one fragment per 5 cycles.
REQ-026 In IDLE with in_valid=0, no register SHALL change.

Reset
REQ-027 On any edge with rst=1, regardless of state (mid-RUN included), the block SHALL set state=IDLE, idx=0, frag_q=0, swz_q=0 and out_frag=0.
REQ-028 While rst is high, out_valid, in_ready and busy SHALL be 0, and mix_from SHALL be 0.
REQ-029 A transfer interrupted by reset SHALL be discarded with no partial output.

Verification
REQ-030 Identity: swizzle 0xE4, frag 0xABCD, out_ready=1 -> out_valid 4 cycles after accept, out_frag=0xABCD, mix_from sequence 0,1,2,3.
REQ-031 Reverse and broadcast: swizzle 0x1B, frag 0x1234 -> out_frag 0x4321 and mix_from 3,2,1,0; swizzle 0x00, frag 0x1234 -> out_frag 0x4444.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid held 1, out_frag unchanged, in_ready=0, and a pending in_valid is not accepted.
REQ-033 Back-to-back: in_valid held with two pairs, out_ready=1 -> second accept occurs in the DONE cycle, outputs arrive in order 5 cycles apart, and IDLE is never entered.
REQ-034 Reset mid-RUN at idx=2 -> next cycle busy=0, out_valid=0, out_frag=0x0000, in_ready=1 after rst drops, and the next pair completes correctly.
REQ-035 Idle hold: in_valid=0 for 20 cycles after reset -> in_ready=1, busy=0, and all outputs constant.
